// File: rtl/usr_seq_pkg.sv
// rtl/usr_seq_pkg.sv - shared encodings for the usr command sequencer
package usr_seq_pkg;

    // Command opcodes as seen on cmd_op
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROTR = 2'b11
    } op_t;

    // Mode encodings understood by the usr shift register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/usr_seq_usr.sv
// rtl/usr_seq_usr.sv - 4-bit universal shift register (hold/shr/shl/load)
module usr
    import usr_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [3:0] datain,
    output logic [3:0] dataout
);

    // Register update: serial bit always comes from datain[0]
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataout <= 4'b0000;
        end else begin
            case (mode)
                MODE_SHR:  dataout <= {datain[0], dataout[3:1]};
                MODE_SHL:  dataout <= {dataout[2:0], datain[0]};
                MODE_LOAD: dataout <= datain;
                default:   dataout <= dataout;
            endcase
        end
    end

endmodule

// File: rtl/usr_seq.sv
// rtl/usr_seq.sv - command sequencer driving the usr shift register
module usr_seq
    import usr_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_sin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t             state;
    op_t                op_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   count_q;
    logic               sin_q;
    logic [CNT_W-1:0]   remaining;

    logic [1:0]         mode;
    logic [WIDTH-1:0]   datain;
    logic [WIDTH-1:0]   dout;

    usr u_usr (
        .clock   (clock),
        .reset   (reset),
        .mode    (mode),
        .datain  (datain),
        .dataout (dout)
    );

    // The register holds outside RESP too, so its output is the response payload directly
    assign rsp_data = dout;

    // Mode/data mux: only EXEC moves the register, everything else holds
    always_comb begin
        mode   = MODE_HOLD;
        datain = '0;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_LOAD: begin
                    mode   = MODE_LOAD;
                    datain = data_q;
                end
                OP_SHR: begin
                    mode   = MODE_SHR;
                    datain = {{(WIDTH-1){1'b0}}, sin_q};
                end
                OP_SHL: begin
                    mode   = MODE_SHL;
                    datain = {{(WIDTH-1){1'b0}}, sin_q};
                end
                default: begin
                    // Rotate right is a right shift that refills with the outgoing LSB
                    mode   = MODE_SHR;
                    datain = {{(WIDTH-1){1'b0}}, dout[0]};
                end
            endcase
        end
    end

    // Control FSM with registered handshake/status outputs and step counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            count_q   <= '0;
            sin_q     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        data_q    <= cmd_data;
                        count_q   <= cmd_count;
                        sin_q     <= cmd_sin;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (op_t'(cmd_op) == OP_LOAD) begin
                            remaining <= CNT_W'(1);
                            state     <= ST_EXEC;
                        end else if (cmd_count != '0) begin
                            remaining <= cmd_count;
                            state     <= ST_EXEC;
                        end else begin
                            // Zero-step shift: nothing to execute, answer with current contents
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // Return to IDLE for at least one cycle before the next accept
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_seq.sv
// tb/tb_usr_seq.sv - self-checking bench for usr_seq
module tb_usr_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'b0000;
    logic [2:0] cmd_count = 3'd0;
    logic       cmd_sin = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    int         lat_q[$];

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [2:0] count;
        logic       sin;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[12];

    usr_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .cmd_sin   (cmd_sin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command, push its expectation, wait for the response and score it
    task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c,
                         input logic s, input logic [3:0] exp_d, input int exp_lat);
        int lat;
        logic [3:0] ed;
        int el;
        @(negedge clock);
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = c;
        cmd_sin   = s;
        exp_q.push_back(exp_d);
        lat_q.push_back(exp_lat);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
        while (!rsp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        ed = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        end else begin
            chk("rsp_data", 32'(rsp_data), 32'(ed));
            chk("rsp_latency", 32'(lat), 32'(el));
        end
    endtask

    // Complete the response handshake and confirm the return to IDLE
    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("busy_after_hs", 32'(busy), 32'd0);
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 4'b1010, 3'd0, 1'b0, 4'b1010, 2};
        vecs[1]  = '{2'b00, 4'b0000, 3'd0, 1'b0, 4'b0000, 2};
        vecs[2]  = '{2'b01, 4'b0000, 3'd2, 1'b1, 4'b1100, 3};
        vecs[3]  = '{2'b10, 4'b0000, 3'd3, 1'b1, 4'b0111, 4};
        vecs[4]  = '{2'b11, 4'b0000, 3'd1, 1'b0, 4'b1011, 2};
        vecs[5]  = '{2'b11, 4'b0000, 3'd4, 1'b0, 4'b1011, 5};
        vecs[6]  = '{2'b01, 4'b1111, 3'd0, 1'b1, 4'b1011, 1};
        vecs[7]  = '{2'b01, 4'b0000, 3'd7, 1'b0, 4'b0000, 8};
        vecs[8]  = '{2'b10, 4'b0000, 3'd7, 1'b1, 4'b1111, 8};
        vecs[9]  = '{2'b00, 4'b0110, 3'd5, 1'b1, 4'b0110, 2};
        vecs[10] = '{2'b11, 4'b0000, 3'd7, 1'b1, 4'b1100, 8};
        vecs[11] = '{2'b10, 4'b0000, 3'd2, 1'b0, 4'b0000, 3};

        // Reset state
        #12;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven command sequence
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].sin,
                  vecs[i].exp_data, vecs[i].exp_lat);
            finish_rsp();
        end

        // Response backpressure while a master keeps offering commands
        rsp_ready = 1'b0;
        issue(2'b00, 4'b0011, 3'd0, 1'b0, 4'b0011, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_data  = 4'b1111;
            @(posedge clock);
            #1;
            cmd_valid = 1'b0;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h3);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        finish_rsp();
        issue(2'b01, 4'b0000, 3'd1, 1'b0, 4'b0001, 2);
        finish_rsp();

        // Reset in the middle of a long shift
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 3'd7;
        cmd_sin   = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midreset_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        issue(2'b00, 4'b0101, 3'd0, 1'b0, 4'b0101, 2);
        finish_rsp();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usr_seq.md
Name: usr_seq

Overview:
- Command sequencer for the 4-bit universal shift register `usr`; `usr_seq` instantiates it internally.
- Accepts one command at a time over a valid/ready handshake.
- Drives the usr MODE/DATAIN inputs for the required number of cycles, then returns the register contents over a second valid/ready handshake.
- Sits between a control master and the shared shift register, so masters never drive MODE directly.

Parameters:
- WIDTH, 4, register width; fixed at 4 to match usr, other values unsupported.
- CNT_W, 3, width of the shift-count field; max shift steps per command = 2^CNT_W-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer accepts a command this cycle.
- cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROTR.
- cmd_data  input  WIDTH  parallel load value (LOAD only).
- cmd_count  input  CNT_W  number of shift steps (shift ops only).
- cmd_sin  input  1  serial fill bit for SHR/SHL.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  master takes the result.
- rsp_data  output  WIDTH  register contents after the command.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- usr contract (internal instance):
  - MODE 00 hold.
  - MODE 01 shift right, DATAIN[0] enters MSB.
  - MODE 10 shift left, DATAIN[0] enters LSB.
  - MODE 11 parallel load DATAIN.
  - Register cleared by reset; updates on the rising clock edge.
- Reset (async, immediate):
  - FSM to IDLE; cmd_ready=1, rsp_valid=0, busy=0.
  - rsp_data=0; usr register=0; latched command fields=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1; usr MODE=00.
  - On cmd_valid, latch op/data/count/sin at the edge (accept edge T).
  - LOAD: remaining=1, go EXEC.
  - Shift op with count!=0: remaining=count, go EXEC.
  - Shift op with count==0: go RESP directly, register unchanged.
- EXEC:
  - cmd_ready=0. Each cycle, MODE and DATAIN are driven combinationally from the latched op:
    - LOAD: MODE=11, DATAIN=data.
    - SHR: MODE=01, DATAIN={000,sin}.
    - SHL: MODE=10, DATAIN={000,sin}.
    - ROTR: MODE=01, DATAIN={000,usr_dout[0]}.
  - remaining decrements each edge; when remaining==1, next state is RESP.
- RESP:
  - MODE=00 (hold); rsp_valid=1; rsp_data=usr DATAOUT (stable while held).
  - On rsp_valid&&rsp_ready, go IDLE.
  - Results are never dropped or overwritten.
- Latency, with accept at edge T:
  - rsp_valid first high in the cycle after edge T+N.
  - N=1 for LOAD, N=count for shifts, N=0 for count 0.
- Backpressure:
  - cmd_valid while not IDLE is ignored, not latched; cmd_ready stays 0.
  - No acceptance in the same cycle as the response handshake; IDLE is always visited for ≥1 cycle.
- Register contents persist between commands; shifts operate on the current value.
- Count saturation: cmd_count = 2^CNT_W-1 executes fully. A ROTR count of 4 returns the original value.
- Reset mid-EXEC or mid-RESP: the pending command and response are discarded.

Decomposition:
- Shared package holds:
  - op encodings OP_LOAD/OP_SHR/OP_SHL/OP_ROTR;
  - usr mode constants MODE_HOLD/MODE_SHR/MODE_SHL/MODE_LOAD;
  - FSM state encoding.
- One sub-module: the existing `usr`, instantiated unchanged.
- FSM, counter and mode/data mux live in `usr_seq`.

Test Plan:
1. Reset, then LOAD cmd_data=1010 (rsp_ready=1) -> rsp_valid high exactly 2 cycles after accept, rsp_data=1010, busy low after the handshake.
2. LOAD 0000, then SHR count=2 sin=1 -> rsp_data=1100, rsp_valid 3 cycles after accept.
3. From 1100, SHL count=3 sin=1 -> intermediate 1001, 0011, final rsp_data=0111.
4. From 0111: ROTR count=1 -> 1011; ROTR count=4 -> 1011 unchanged; SHR count=0 -> rsp_valid 1 cycle after accept, data 1011.
5. Hold rsp_ready=0 for 5 cycles while pulsing cmd_valid -> rsp_data stable, cmd_ready=0, no command accepted; release -> IDLE, then next command accepted normally.
6. Assert reset during EXEC of SHR count=7 -> immediately rsp_valid=0, busy=0, cmd_ready=1, rsp_data=0; next LOAD 0101 returns 0101.
